mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer_if.sv | 22 ++
 rtl/mul_sequencer.sv | 76 +++++++
 tb/tb_mul_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// rtl/mul_sequencer_if.sv - start/operand/result bundle for the shift-add multiply sequencer
interface mul_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             iStart;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             oBusy;
    logic             oDone;
    logic [WIDTH-1:0] oResult;
    logic             oOverflow;

    modport master (
        output iStart, iA, iB,
        input  oBusy, oDone, oResult, oOverflow
    );

    modport slave (
        input  iStart, iA, iB,
        output oBusy, oDone, oResult, oOverflow
    );
endinterface

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative unsigned shift-add multiplier, one step per clock, WIDTH steps per product
module mul_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    mul_sequencer_if.slave   bus
);
    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seqState_t;

    seqState_t          state;
    logic [2*WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic [2*WIDTH-1:0] accum;
    logic [CW-1:0]      stepCount;
    logic [2*WIDTH-1:0] sumNext;

    // Accumulator value after the current step; also feeds the result on the final step.
    assign sumNext = accum + (multiplier[0] ? multiplicand : '0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= IDLE;
            multiplicand  <= '0;
            multiplier    <= '0;
            accum         <= '0;
            stepCount     <= '0;
            bus.oBusy     <= 1'b0;
            bus.oDone     <= 1'b0;
            bus.oResult   <= '0;
            bus.oOverflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        multiplicand <= {{WIDTH{1'b0}}, bus.iA};
                        multiplier   <= bus.iB;
                        accum        <= '0;
                        stepCount    <= '0;
                        state        <= RUN;
                        bus.oBusy    <= 1'b1;
                    end
                end
                RUN: begin
                    accum        <= sumNext;
                    multiplicand <= multiplicand << 1;
                    multiplier   <= multiplier >> 1;
                    stepCount    <= stepCount + CW'(1);
                    if (stepCount == LAST_STEP) begin
                        state         <= DONE;
                        bus.oDone     <= 1'b1;
                        bus.oResult   <= sumNext[WIDTH-1:0];
                        bus.oOverflow <= |sumNext[2*WIDTH-1:WIDTH];
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    bus.oDone <= 1'b0;
                    bus.oBusy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    bus.oDone <= 1'b0;
                    bus.oBusy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - directed-vector bench for mul_sequencer
module tb_mul_sequencer;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    mul_sequencer_if #(.WIDTH(16)) bus ();

    mul_sequencer #(.WIDTH(16)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launches one multiply and measures busy length, done position and results.
    task automatic runMul(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] expRes, input logic expOv, input bit interfere);
        int busyCycles = 0;
        int doneAt     = 0;
        int doneCount  = 0;
        int lateDones  = 0;
        @(negedge Clock);
        bus.iStart = 1'b1;
        bus.iA     = a;
        bus.iB     = b;
        @(negedge Clock);
        bus.iStart = 1'b0;
        bus.iA     = ~a;
        bus.iB     = ~b;
        while (bus.oBusy && busyCycles < 40) begin
            busyCycles++;
            if (bus.oDone) begin
                doneCount++;
                doneAt = busyCycles;
            end
            if (interfere && busyCycles == 3) begin
                bus.iStart = 1'b1;
                bus.iA     = 16'd2;
                bus.iB     = 16'd2;
            end
            if (interfere && busyCycles == 4) bus.iStart = 1'b0;
            @(negedge Clock);
        end
        checkValue({tag, ".busyCycles"}, 32'(busyCycles), 32'd17);
        checkValue({tag, ".doneAt"}, 32'(doneAt), 32'd17);
        checkValue({tag, ".doneCount"}, 32'(doneCount), 32'd1);
        checkValue({tag, ".result"}, {16'd0, bus.oResult}, {16'd0, expRes});
        checkValue({tag, ".overflow"}, {31'd0, bus.oOverflow}, {31'd0, expOv});
        for (int i = 0; i < 20; i++) begin
            if (bus.oDone || bus.oBusy) lateDones++;
            @(negedge Clock);
        end
        checkValue({tag, ".idleQuiet"}, 32'(lateDones), 32'd0);
        checkValue({tag, ".resultHeld"}, {16'd0, bus.oResult}, {16'd0, expRes});
    endtask

    initial begin
        int doneTimes[3];
        int doneSeen;
        int wrongRes;
        int drain;
        int strayDone;

        bus.iStart = 1'b1;
        bus.iA     = 16'h1234;
        bus.iB     = 16'h5678;
        Reset      = 1'b1;
        repeat (3) @(negedge Clock);
        checkValue("reset.busy", {31'd0, bus.oBusy}, 32'd0);
        checkValue("reset.done", {31'd0, bus.oDone}, 32'd0);
        checkValue("reset.result", {16'd0, bus.oResult}, 32'd0);
        checkValue("reset.overflow", {31'd0, bus.oOverflow}, 32'd0);
        bus.iStart = 1'b0;
        Reset      = 1'b0;
        @(negedge Clock);
        checkValue("reset.priority", {31'd0, bus.oBusy}, 32'd0);

        runMul("3x5", 16'd3, 16'd5, 16'h000F, 1'b0, 1'b0);
        runMul("ffffxffff", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
        runMul("00ffx0101", 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0);
        runMul("0100x0100", 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
        runMul("0xffff", 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        runMul("7x9interfere", 16'd7, 16'd9, 16'h003F, 1'b0, 1'b1);

        // iStart held high: completions every 18 cycles starting at edge 16.
        doneSeen = 0;
        wrongRes = 0;
        @(negedge Clock);
        bus.iStart = 1'b1;
        bus.iA     = 16'd4;
        bus.iB     = 16'd4;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clock);
            if (bus.oDone) begin
                if (doneSeen < 3) doneTimes[doneSeen] = c;
                doneSeen++;
                if (bus.oResult !== 16'h0010) wrongRes++;
            end
        end
        bus.iStart = 1'b0;
        checkValue("held.doneCount", 32'(doneSeen), 32'd3);
        checkValue("held.done0", 32'(doneTimes[0]), 32'd16);
        checkValue("held.done1", 32'(doneTimes[1]), 32'd34);
        checkValue("held.done2", 32'(doneTimes[2]), 32'd52);
        checkValue("held.results", 32'(wrongRes), 32'd0);
        drain = 0;
        while (bus.oBusy && drain < 40) begin
            drain++;
            @(negedge Clock);
        end
        checkValue("held.drained", {31'd0, bus.oBusy}, 32'd0);

        // Reset sampled on the 5th RUN edge aborts without a completion.
        @(negedge Clock);
        bus.iStart = 1'b1;
        bus.iA     = 16'd3;
        bus.iB     = 16'd5;
        @(negedge Clock);
        bus.iStart = 1'b0;
        repeat (4) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        checkValue("abort.busy", {31'd0, bus.oBusy}, 32'd0);
        checkValue("abort.done", {31'd0, bus.oDone}, 32'd0);
        checkValue("abort.result", {16'd0, bus.oResult}, 32'd0);
        strayDone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (bus.oDone || bus.oBusy) strayDone++;
        end
        checkValue("abort.quiet", 32'(strayDone), 32'd0);
        runMul("2x3afterAbort", 16'd2, 16'd3, 16'h0006, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
